// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter and its
// round-robin selector.
`timescale 1ns/1ps
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_M0   = 2'b01;
  localparam logic [1:0] ACK_M1   = 2'b10;

  localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// master = requesting side, slave = arbiter side.
`timescale 1ns/1ps
interface bus_arbiter_if;

  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] ack;
  logic       busy;
  logic       owner;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  ack,
    input  busy,
    input  owner,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output ack,
    output busy,
    output owner,
    output timeout
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational two-input round-robin selector: on a tie the master that
// did not win last time is chosen.
`timescale 1ns/1ps
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a one-cycle turnaround between owners.
// Optional forced release after MAX_HOLD granted cycles: define BUS_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.slave  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_params
    $error("bus_arbiter: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       pick_winner, pick_valid;
  logic       granted, cur;
  logic       tmo_fire, exit_grant;
  logic [1:0] ack_int;

  rr_pick u_pick (
    .req    (bus.req),
    .last   (owner_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign granted = (state_reg == GRANT0) || (state_reg == GRANT1);
  assign cur     = (state_reg == GRANT1);

`ifdef BUS_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             timeout_reg;

  // Fires on the MAX_HOLD-th granted cycle; a coincident done is a normal release
  assign tmo_fire = granted && (hold_cnt_reg == CNT_W'(MAX_HOLD - 1)) && !bus.done[cur];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= tmo_fire;
      if (!granted)
        hold_cnt_reg <= '0;
      else if (hold_cnt_reg != CNT_W'(MAX_HOLD))
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end

  assign bus.timeout = timeout_reg;
`else
  assign tmo_fire    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign exit_grant = bus.done[cur] || !bus.req[cur] || tmo_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      IDLE, RELEASE: begin
        if (pick_valid) begin
          state_next = pick_winner ? GRANT1 : GRANT0;
          owner_next = pick_winner;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (exit_grant)
          state_next = RELEASE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode the state register only, so ack never glitches with req/done
  always_comb begin
    ack_int = ACK_NONE;
    case (state_reg)
      GRANT0:  ack_int = ACK_M0;
      GRANT1:  ack_int = ACK_M1;
      default: ack_int = ACK_NONE;
    endcase
  end

  assign bus.ack   = ack_int;
  assign bus.busy  = (ack_int != ACK_NONE);
  assign bus.owner = owner_reg;

endmodule
